sram_req_bridge: RTL and testbench
==================================

// Module: sram_req_bridge
// PURPOSE
//  Merges NCH like-SRAM request channels (ch0 = fetch, ch1 = load/store by default) onto one
//  split-transaction memory port. Tracks up to DEPTH outstanding requests; returns responses in order.
//  Sits between the pipeline stages and the single unified memory or AXI-bridge port.
//  Replaces the fixed, always-ready inst/data SRAM pair.
// PARAMETERS
//  NCH    2   number of requesting channels (>=1); higher index = higher fixed priority
//  DEPTH  4   max outstanding accepted-but-unanswered requests (power of 2, >=2)
//  AW     32  address width
//  DW     32  data width (wstrb width = DW/8)
// PORTS
//  clk          in   1          clock; all state updates on rising edge
//  reset        in   1          synchronous, active-high
//  ch_req       in   NCH        per-channel request; must stay high with fields stable until addr_ok
//  ch_wr        in   NCH        1 = write
//  ch_size      in   NCH*2      0 = byte, 1 = half, 2 = word
//  ch_wstrb     in   NCH*DW/8   byte enables (writes)
//  ch_addr      in   NCH*AW     request address
//  ch_wdata     in   NCH*DW     write data
//  ch_addr_ok   out  NCH        request accepted this cycle (one-hot or zero)
//  ch_data_ok   out  NCH        response for this channel this cycle (one-hot or zero)
//  ch_rdata     out  DW         read data, broadcast; valid with ch_data_ok
//  mem_req      out  1          request to memory
//  mem_wr/size/wstrb/addr/wdata  out  1/2/DW/8/AW/DW   fields muxed from granted channel
//  mem_addr_ok  in   1          memory accepts request this cycle
//  mem_data_ok  in   1          memory returns a response this cycle (strictly in order)
//  mem_rdata    in   DW         response data
//  err_unexp    out  1          sticky: mem_data_ok seen with no request outstanding
// BEHAVIOUR
//  - Reset: ID FIFO empty, lock cleared, err_unexp=0, ch_addr_ok=0, ch_data_ok=0, mem_req=0.
//  - Grant: when unlocked, grant = highest-index ch_req. mem_req = |ch_req & !full.
//    mem_* fields = granted channel fields (0 when mem_req=0).
//  - Lock: mem_req=1 && !mem_addr_ok -> latch grant; keep the same channel next cycle regardless of
//    higher-priority requests. Lock clears on the handshake. Lock also clears if the locked channel drops
//    ch_req (protocol violation; the request is dropped).
//  - Handshake: mem_req && mem_addr_ok -> ch_addr_ok[grant]=1 same cycle (combinational);
//    push grant ID (clog2(NCH), min 1 bit) into FIFO.
//  - Response: mem_data_ok && !empty -> ch_data_ok[head]=1 same cycle, ch_rdata=mem_rdata; pop.
//  - Response with FIFO empty: ignored (no ch_data_ok) and err_unexp set until reset.
//  - Full (count==DEPTH): mem_req forced 0, even if a pop occurs the same cycle (no bypass).
//  - Push and pop in the same cycle: both occur, count unchanged; wrap-around by pointer mod DEPTH.
//  - Latency: addr_ok 0 cycles after mem_addr_ok; data_ok 0 cycles after mem_data_ok.
//    Zero added cycles; no buffering of data.
//  - Reset mid-operation: outstanding IDs discarded. The memory must also be reset; late responses set err_unexp.
//  - Counter width: clog2(DEPTH)+1; never exceeds DEPTH.
// CONFIGURATION
//  SRAM_BRIDGE_RR_EN defined: the unlocked grant is round-robin.
//    Search starts at (last granted index + 1) mod NCH. The last-granted register updates on each handshake
//    and resets to NCH-1, so ch0 wins first.
//  Not defined: fixed priority, highest index wins. Lock behaviour is identical in both modes.
// STRUCTURE
//  - Shared header DEFINE.vh: size encodings (BYTE/HALF/WORD) and a macro computing ID width from NCH.
//  - Sub-module resp_id_fifo: parametrised DEPTH x ID-width sync FIFO.
//    Ports: push/pop, full/empty, head, count.
//  - Top: arbiter + lock register + field mux + response demux.
// TESTING
//  1 Single read: ch0 req addr 0x1C000000, mem_addr_ok=1 same cycle -> ch_addr_ok=01; 3 cycles later
//    mem_data_ok, rdata 0xDEADBEEF -> ch_data_ok=01, ch_rdata=0xDEADBEEF.
//  2 Contention: ch0 and ch1 req together, fixed mode -> ch1 granted first, ch0 next cycle.
//    RR_EN -> ch0 first, then ch1.
//  3 Lock: ch0 req, mem_addr_ok=0 for 2 cycles while ch1 raises req -> mem_addr stays ch0's;
//    accepted on cycle 3, then ch1.
//  4 Full: 4 accepted, no responses -> mem_req=0 with ch1 still requesting.
//    mem_data_ok on cycle N -> mem_req=1 at N+1; responses route ch0,ch1,ch0,ch1 in issue order.
//  5 Unexpected response: after reset, mem_data_ok=1 -> ch_data_ok=00, err_unexp=1 until reset.
//  6 Reset with 3 outstanding -> next cycle empty, mem_req follows ch_req; FIFO count=0.

Source files
------------

// File: rtl/sram_req_bridge_pkg.sv
// Shared definitions for sram_req_bridge: request size encodings and the ID-width helper.
package sram_req_bridge_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Channel ID width; a single channel still carries a 1-bit ID.
    function automatic int unsigned id_width(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/sram_req_bridge_resp_id_fifo.sv
// DEPTH x IW synchronous FIFO holding the channel ID of every accepted, unanswered request.
module sram_req_bridge_resp_id_fifo
    import sram_req_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IW    = 1,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [IW-1:0] push_id,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [IW-1:0] head,
    output logic [CW-1:0] count
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] storage_q [DEPTH];
    logic [IW-1:0] storage_d [DEPTH];
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = storage_q[rd_ptr_q];
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        storage_d = storage_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push) begin
            storage_d[wr_ptr_q] = push_id;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        storage_q <= storage_d;
    end

endmodule

// File: rtl/sram_req_bridge.sv
// Merges NCH SRAM-like request channels onto one split-transaction memory port, in-order responses.
// Define SRAM_BRIDGE_RR_EN for round-robin arbitration; fixed priority (highest index) otherwise.
module sram_req_bridge
    import sram_req_bridge_pkg::*;
#(
    parameter int unsigned NCH   = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_wr,
    input  logic [NCH*2-1:0]      ch_size,
    input  logic [NCH*DW/8-1:0]   ch_wstrb,
    input  logic [NCH*AW-1:0]     ch_addr,
    input  logic [NCH*DW-1:0]     ch_wdata,
    output logic [NCH-1:0]        ch_addr_ok,
    output logic [NCH-1:0]        ch_data_ok,
    output logic [DW-1:0]         ch_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [DW/8-1:0]       mem_wstrb,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DW-1:0]         mem_rdata,
    output logic                  err_unexp
);

    localparam int unsigned IW = id_width(NCH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = DW / 8;

    logic [IW-1:0] grant;
    logic          lock_q, lock_d;
    logic [IW-1:0] lock_id_q, lock_id_d;
    logic          err_q, err_d;
    logic          handshake, resp_pop;
    logic          fifo_full, fifo_empty;
    logic [IW-1:0] fifo_head;
    logic [CW-1:0] fifo_count;

`ifdef SRAM_BRIDGE_RR_EN
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] rr_idx;
    logic          rr_found;
`endif

    // A held lock wins outright; a dropped locked request falls back to normal arbitration.
    always_comb begin
        grant = '0;
`ifdef SRAM_BRIDGE_RR_EN
        rr_idx   = '0;
        rr_found = 1'b0;
`endif
        if (lock_q && ch_req[lock_id_q]) begin
            grant = lock_id_q;
        end else begin
`ifdef SRAM_BRIDGE_RR_EN
            for (int i = 1; i <= NCH; i++) begin
                rr_idx = IW'((int'(last_q) + i) % NCH);
                if (!rr_found && ch_req[rr_idx]) begin
                    grant    = rr_idx;
                    rr_found = 1'b1;
                end
            end
`else
            for (int i = 0; i < NCH; i++) begin
                if (ch_req[i]) grant = IW'(i);
            end
`endif
        end
    end

    assign mem_req   = (|ch_req) & ~fifo_full;
    assign handshake = mem_req & mem_addr_ok;
    assign resp_pop  = mem_data_ok & ~fifo_empty;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_req) begin
            mem_wr    = ch_wr[grant];
            mem_size  = ch_size[int'(grant)*2 +: 2];
            mem_wstrb = ch_wstrb[int'(grant)*SW +: SW];
            mem_addr  = ch_addr[int'(grant)*AW +: AW];
            mem_wdata = ch_wdata[int'(grant)*DW +: DW];
        end
    end

    assign ch_addr_ok = handshake ? (NCH'(1) << grant) : '0;
    assign ch_data_ok = resp_pop ? (NCH'(1) << fifo_head) : '0;
    assign ch_rdata   = mem_rdata;
    assign err_unexp  = err_q;

    always_comb begin
        lock_d    = mem_req & ~mem_addr_ok;
        lock_id_d = grant;
        err_d     = err_q | (mem_data_ok & fifo_empty);
`ifdef SRAM_BRIDGE_RR_EN
        last_d    = handshake ? grant : last_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
`ifdef SRAM_BRIDGE_RR_EN
            last_q    <= IW'(NCH - 1);
`endif
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
`ifdef SRAM_BRIDGE_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    sram_req_bridge_resp_id_fifo #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (handshake),
        .push_id (grant),
        .pop     (resp_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head),
        .count   (fifo_count)
    );

    assert property (@(posedge clk) disable iff (reset) fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_sram_req_bridge.sv
// Self-checking bench for sram_req_bridge: per-scenario tasks with a response scoreboard.
module tb_sram_req_bridge;
    import sram_req_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ch_req, ch_wr;
    logic [3:0]  ch_size;
    logic [7:0]  ch_wstrb;
    logic [63:0] ch_addr, ch_wdata;
    logic [1:0]  ch_addr_ok, ch_data_ok;
    logic [31:0] ch_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        err_unexp;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sram_req_bridge #(
        .NCH   (2),
        .DEPTH (4),
        .AW    (32),
        .DW    (32)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .ch_req      (ch_req),
        .ch_wr       (ch_wr),
        .ch_size     (ch_size),
        .ch_wstrb    (ch_wstrb),
        .ch_addr     (ch_addr),
        .ch_wdata    (ch_wdata),
        .ch_addr_ok  (ch_addr_ok),
        .ch_data_ok  (ch_data_ok),
        .ch_rdata    (ch_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_wstrb   (mem_wstrb),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .err_unexp   (err_unexp)
    );

    task automatic set_idle();
        ch_req      = '0;
        ch_wr       = '0;
        ch_size     = '0;
        ch_wstrb    = '0;
        ch_addr     = '0;
        ch_wdata    = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
    endtask

    task automatic set_ch(input int c, input logic [31:0] a, input logic w, input logic [31:0] d);
        ch_addr[c*32 +: 32]  = a;
        ch_wdata[c*32 +: 32] = d;
        ch_wr[c]             = w;
        ch_size[c*2 +: 2]    = SIZE_WORD;
        ch_wstrb[c*4 +: 4]   = w ? 4'hF : 4'h0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        ch_req = 2'b11;
        @(posedge clk);
        #1;
        checks++;
        if (ch_addr_ok !== 2'b00 || ch_data_ok !== 2'b00 || err_unexp !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: addr_ok=%b data_ok=%b err=%b want 00 00 0",
                     ch_addr_ok, ch_data_ok, err_unexp);
        end
        checks++;
        if (u_dut.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", u_dut.fifo_count);
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_req: got %b want 0", mem_req);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        exp_t e;
        apply_reset();
        @(negedge clk);
        set_ch(0, 32'h1C00_0000, 1'b0, 32'h0);
        ch_req      = 2'b01;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1C00_0000 || ch_addr_ok !== 2'b01
            || mem_wr !== 1'b0 || mem_size !== SIZE_WORD) begin
            errors++;
            $display("FAIL single_req: req=%b addr=%h addr_ok=%b wr=%b size=%0d want 1 1c000000 01 0 2",
                     mem_req, mem_addr, ch_addr_ok, mem_wr, mem_size);
        end
        sb.push_back('{ch: 0, data: 32'hDEAD_BEEF});
        @(posedge clk);
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL single_idle: req=%b addr=%h want 0 00000000", mem_req, mem_addr);
        end
        repeat (2) @(negedge clk);
        e           = sb.pop_front();
        mem_data_ok = 1'b1;
        mem_rdata   = e.data;
        #1;
        checks++;
        if (ch_data_ok !== 2'(1 << e.ch) || ch_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_resp: data_ok=%b rdata=%h want 01 deadbeef", ch_data_ok, ch_rdata);
        end
        @(posedge clk);
        @(negedge clk);
        mem_data_ok = 1'b0;
    endtask

    task automatic test_contention();
        exp_t        e;
        int          first, second;
        logic [31:0] addr [2];
        addr[0] = 32'h0000_1000;
        addr[1] = 32'h0000_2000;
`ifdef SRAM_BRIDGE_RR_EN
        first = 0;
`else
        first = 1;
`endif
        second = 1 - first;
        apply_reset();
        @(negedge clk);
        set_ch(0, addr[0], 1'b0, 32'h0);
        set_ch(1, addr[1], 1'b1, 32'hA5A5_0001);
        ch_req      = 2'b11;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (ch_addr_ok !== 2'(1 << first) || mem_addr !== addr[first]) begin
            errors++;
            $display("FAIL contend_first: addr_ok=%b addr=%h want %b %h",
                     ch_addr_ok, mem_addr, 2'(1 << first), addr[first]);
        end
        sb.push_back('{ch: first, data: 32'h1111_0000});
        @(posedge clk);
        @(negedge clk);
        ch_req[first] = 1'b0;
        #1;
        checks++;
        if (ch_addr_ok !== 2'(1 << second) || mem_addr !== addr[second]
            || mem_wr !== ch_wr[second]) begin
            errors++;
            $display("FAIL contend_second: addr_ok=%b addr=%h wr=%b want %b %h %b",
                     ch_addr_ok, mem_addr, mem_wr, 2'(1 << second), addr[second], ch_wr[second]);
        end
        checks++;
        if (ch_wr[1] && (mem_wdata !== 32'hA5A5_0001 || mem_wstrb !== 4'hF) && second == 1) begin
            errors++;
            $display("FAIL contend_wfields: wdata=%h wstrb=%h want a5a50001 f", mem_wdata, mem_wstrb);
        end
        sb.push_back('{ch: second, data: 32'h2222_0000});
        @(posedge clk);
        @(negedge clk);
        set_idle();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            mem_data_ok = 1'b1;
            mem_rdata   = e.data;
            #1;
            checks++;
            if (ch_data_ok !== 2'(1 << e.ch) || ch_rdata !== e.data) begin
                errors++;
                $display("FAIL contend_resp: data_ok=%b rdata=%h want %b %h",
                         ch_data_ok, ch_rdata, 2'(1 << e.ch), e.data);
            end
            @(posedge clk);
        end
        @(negedge clk);
        mem_data_ok = 1'b0;
    endtask

    task automatic test_lock();
        exp_t e;
        apply_reset();
        @(negedge clk);
        set_ch(0, 32'h0000_0A00, 1'b0, 32'h0);
        set_ch(1, 32'h0000_0B00, 1'b0, 32'h0);
        ch_req = 2'b01;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0A00 || ch_addr_ok !== 2'b00) begin
            errors++;
            $display("FAIL lock_c1: req=%b addr=%h addr_ok=%b want 1 00000a00 00",
                     mem_req, mem_addr, ch_addr_ok);
        end
        @(posedge clk);
        @(negedge clk);
        ch_req = 2'b11;
        #1;
        checks++;
        if (mem_addr !== 32'h0000_0A00 || ch_addr_ok !== 2'b00) begin
            errors++;
            $display("FAIL lock_c2: addr=%h addr_ok=%b want 00000a00 00", mem_addr, ch_addr_ok);
        end
        @(posedge clk);
        @(negedge clk);
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (mem_addr !== 32'h0000_0A00 || ch_addr_ok !== 2'b01) begin
            errors++;
            $display("FAIL lock_c3: addr=%h addr_ok=%b want 00000a00 01", mem_addr, ch_addr_ok);
        end
        sb.push_back('{ch: 0, data: 32'h3333_0000});
        @(posedge clk);
        @(negedge clk);
        ch_req = 2'b10;
        #1;
        checks++;
        if (mem_addr !== 32'h0000_0B00 || ch_addr_ok !== 2'b10) begin
            errors++;
            $display("FAIL lock_next: addr=%h addr_ok=%b want 00000b00 10", mem_addr, ch_addr_ok);
        end
        sb.push_back('{ch: 1, data: 32'h4444_0000});
        @(posedge clk);
        @(negedge clk);
        set_idle();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            mem_data_ok = 1'b1;
            mem_rdata   = e.data;
            #1;
            checks++;
            if (ch_data_ok !== 2'(1 << e.ch) || ch_rdata !== e.data) begin
                errors++;
                $display("FAIL lock_resp: data_ok=%b rdata=%h want %b %h",
                         ch_data_ok, ch_rdata, 2'(1 << e.ch), e.data);
            end
            @(posedge clk);
        end
        @(negedge clk);
        mem_data_ok = 1'b0;
    endtask

    task automatic test_full();
        exp_t e;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_idle();
            set_ch(k % 2, 32'h0000_4000 + 32'(k * 4), 1'b0, 32'h0);
            ch_req      = 2'(1 << (k % 2));
            mem_addr_ok = 1'b1;
            #1;
            checks++;
            if (ch_addr_ok !== 2'(1 << (k % 2))) begin
                errors++;
                $display("FAIL full_fill%0d: addr_ok=%b want %b", k, ch_addr_ok, 2'(1 << (k % 2)));
            end
            sb.push_back('{ch: k % 2, data: 32'h5000_0000 + 32'(k)});
            @(posedge clk);
        end
        @(negedge clk);
        set_ch(1, 32'h0000_4100, 1'b0, 32'h0);
        ch_req = 2'b10;
        #1;
        checks++;
        if (mem_req !== 1'b0 || ch_addr_ok !== 2'b00) begin
            errors++;
            $display("FAIL full_block: req=%b addr_ok=%b want 0 00", mem_req, ch_addr_ok);
        end
        @(posedge clk);
        @(negedge clk);
        e           = sb.pop_front();
        mem_data_ok = 1'b1;
        mem_rdata   = e.data;
        #1;
        checks++;
        if (mem_req !== 1'b0 || ch_data_ok !== 2'(1 << e.ch) || ch_rdata !== e.data) begin
            errors++;
            $display("FAIL full_nobypass: req=%b data_ok=%b rdata=%h want 0 %b %h",
                     mem_req, ch_data_ok, ch_rdata, 2'(1 << e.ch), e.data);
        end
        @(posedge clk);
        @(negedge clk);
        mem_data_ok = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || ch_addr_ok !== 2'b10 || mem_addr !== 32'h0000_4100) begin
            errors++;
            $display("FAIL full_resume: req=%b addr_ok=%b addr=%h want 1 10 00004100",
                     mem_req, ch_addr_ok, mem_addr);
        end
        sb.push_back('{ch: 1, data: 32'h5000_0004});
        @(posedge clk);
        @(negedge clk);
        set_idle();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            mem_data_ok = 1'b1;
            mem_rdata   = e.data;
            #1;
            checks++;
            if (ch_data_ok !== 2'(1 << e.ch) || ch_rdata !== e.data) begin
                errors++;
                $display("FAIL full_resp: data_ok=%b rdata=%h want %b %h",
                         ch_data_ok, ch_rdata, 2'(1 << e.ch), e.data);
            end
            @(posedge clk);
        end
        @(negedge clk);
        mem_data_ok = 1'b0;
    endtask

    task automatic test_unexpected();
        apply_reset();
        #1;
        checks++;
        if (err_unexp !== 1'b0) begin
            errors++;
            $display("FAIL unexp_init: err=%b want 0", err_unexp);
        end
        @(negedge clk);
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1234_5678;
        #1;
        checks++;
        if (ch_data_ok !== 2'b00) begin
            errors++;
            $display("FAIL unexp_dataok: got %b want 00", ch_data_ok);
        end
        @(posedge clk);
        @(negedge clk);
        mem_data_ok = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (err_unexp !== 1'b1) begin
            errors++;
            $display("FAIL unexp_sticky: err=%b want 1", err_unexp);
        end
        apply_reset();
        #1;
        checks++;
        if (err_unexp !== 1'b0) begin
            errors++;
            $display("FAIL unexp_clear: err=%b want 0", err_unexp);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_ch(0, 32'h0000_6000 + 32'(k * 4), 1'b0, 32'h0);
            ch_req      = 2'b01;
            mem_addr_ok = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (u_dut.fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL mid_count3: got %0d want 3", u_dut.fifo_count);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        set_ch(1, 32'h0000_7000, 1'b0, 32'h0);
        ch_req = 2'b10;
        #1;
        checks++;
        if (u_dut.fifo_count !== 3'd0 || mem_req !== 1'b1 || mem_addr !== 32'h0000_7000) begin
            errors++;
            $display("FAIL mid_after: count=%0d req=%b addr=%h want 0 1 00007000",
                     u_dut.fifo_count, mem_req, mem_addr);
        end
        mem_data_ok = 1'b1;
        #1;
        checks++;
        if (ch_data_ok !== 2'b00) begin
            errors++;
            $display("FAIL mid_late: data_ok=%b want 00", ch_data_ok);
        end
        @(posedge clk);
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (err_unexp !== 1'b1) begin
            errors++;
            $display("FAIL mid_err: err=%b want 1", err_unexp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        set_idle();
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_full();
        test_unexpected();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
